truth_table_sweeper: RTL and testbench

- Sequencer that exhaustively exercises a pair of small combinational benchmark circuits, typically the ORIGINAL and BALANCED netlists of one generated circuit.
- Drives every input vector 0..2^N_IN-1 onto a shared input bus, waits a settle interval, samples both response buses, and compares them bit-for-bit.
- Accumulates a fail count, the first failing vector, and a 32-bit MISR signature of response A, for dataset equivalence checking.
- Sits in the dataset validation harness, between the harness controller (start/done) and the two circuit instances.

---
 rtl/truth_table_sweeper.sv | 171 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive equivalence sweeper for a pair of small combinational circuits
//   (typically the ORIGINAL and BALANCED netlists of one generated circuit).
//   Every input vector 0..2^N_IN-1 is driven onto a shared bus. The sweeper
//   waits SETTLE cycles, samples both response buses in a single SAMPLE cycle
//   and compares them. It accumulates a mismatch count, the lowest failing
//   vector, and a 32-bit MISR signature of response A.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   begin a sweep (accepted only in IDLE)
//   abort          in   stop a running sweep (accepted in SETTLE/SAMPLE)
//   vec            out  [N_IN]    vector driven to both circuits
//   resp_a         in   [N_OUT]   circuit A outputs
//   resp_b         in   [N_OUT]   circuit B outputs
//   busy           out  high in SETTLE/SAMPLE/DONE
//   done           out  one-cycle pulse when a sweep completes (never on abort)
//   pass           out  1 iff the completed sweep saw no mismatch
//   fail_count     out  [N_IN+1]  number of mismatching vectors
//   first_fail_vec out  [N_IN]    lowest mismatching vector, 0 if none
//   signature      out  [32]      MISR over resp_a
//
// All outputs come straight from registers, so there is no combinational
// path from resp_a/resp_b to any output.

module truth_table_sweeper #(
  parameter int          N_IN   = 4,
  parameter int          N_OUT  = 19,
  parameter int          SETTLE = 1,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec,
  input  logic [N_OUT-1:0]  resp_a,
  input  logic [N_OUT-1:0]  resp_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     fail_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [31:0]       signature
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // The settle counter only has to reach SETTLE-1.
  localparam int             CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_settle_cnt;
  logic [N_IN-1:0]  r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [N_IN:0]    r_fail_count;
  logic [N_IN-1:0]  r_first_fail;
  logic [31:0]      r_sig;

  logic             w_mismatch;
  logic             w_last_vec;
  logic [31:0]      w_resp_ext;
  logic [31:0]      w_sig_next;
  logic [N_IN:0]    w_fail_inc;

  always_comb begin
    w_mismatch = (resp_a != resp_b);
    w_last_vec = (r_vec == '1);
    w_resp_ext = 32'(resp_a);
    w_sig_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : '0) ^ w_resp_ext;
    w_fail_inc = r_fail_count + {{N_IN{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_sig        <= SEED;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_sig        <= SEED;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state <= S_SAMPLE;
            end
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            // Partial results are frozen; this vector is not accounted.
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_mismatch) begin
              r_fail_count <= w_fail_inc;
              if (r_fail_count == '0) begin
                r_first_fail <= r_vec;
              end
            end
            r_sig <= w_sig_next;
            if (w_last_vec) begin
              // done and pass are registered on entry to DONE so that pass
              // is already valid in the done cycle; it includes this final
              // vector's comparison result.
              r_done  <= 1'b1;
              r_pass  <= (r_fail_count == '0) && !w_mismatch;
              r_state <= S_DONE;
            end else begin
              r_vec        <= r_vec + {{(N_IN-1){1'b0}}, 1'b1};
              r_settle_cnt <= '0;
              r_state      <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          r_pass  <= (r_fail_count == '0);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vec            = r_vec;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail_count     = r_fail_count;
  assign first_fail_vec = r_first_fail;
  assign signature      = r_sig;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed testbench for truth_table_sweeper: one default instance
// (SETTLE=1) and one SETTLE=3 instance, both driven by a 4-in/19-out
// reference circuit model, with mismatches injected on the B side.

module tb_truth_table_sweeper;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  vec;
  logic [18:0] resp_a, resp_b;
  logic        busy, done, pass;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_vec;
  logic [31:0] signature;

  logic        start3 = 1'b0;
  logic [3:0]  vec3;
  logic [18:0] resp3_a, resp3_b;
  logic        busy3, done3, pass3;
  logic [4:0]  fail_count3;
  logic [3:0]  first_fail_vec3;
  logic [31:0] signature3;

  logic [1:0]  mode = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .N_OUT(19), .SETTLE(1), .POLY(POLY), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec),
    .resp_a(resp_a), .resp_b(resp_b), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_vec(first_fail_vec), .signature(signature)
  );

  truth_table_sweeper #(.N_IN(4), .N_OUT(19), .SETTLE(3), .POLY(POLY), .SEED(SEED)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .vec(vec3),
    .resp_a(resp3_a), .resp_b(resp3_b), .busy(busy3), .done(done3), .pass(pass3),
    .fail_count(fail_count3), .first_fail_vec(first_fail_vec3), .signature(signature3)
  );

  // Reference 4-in/19-out circuit.
  function automatic logic [18:0] model(input logic [3:0] v);
    logic [3:0] t;
    logic [3:0] p;
    t = v * 4'd3;
    p = v + 4'd3;
    return {v, ~v, v ^ 4'h9, p, t[2:0]};
  endfunction

  // B-side fault injection per scenario.
  function automatic logic [18:0] inj(input logic [1:0] m, input logic [3:0] v);
    case (m)
      2'd1:    return (v == 4'd5) ? 19'h00080 : 19'h0;
      2'd2:    return 19'h7FFFF;
      2'd3:    return (v == 4'd2 || v == 4'd7) ? 19'h00080 : 19'h0;
      default: return 19'h0;
    endcase
  endfunction

  // MISR over model responses for vectors 0..upto-1.
  function automatic logic [31:0] exp_sig(input int upto);
    logic [31:0] s;
    logic [3:0]  vv;
    s = SEED;
    for (int i = 0; i < upto; i++) begin
      vv = 4'(i);
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {13'h0, model(vv)};
    end
    return s;
  endfunction

  always_comb begin
    resp_a  = model(vec);
    resp_b  = resp_a ^ inj(mode, vec);
    resp3_a = model(vec3);
    resp3_b = ~resp3_a;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep on the default instance and tracks it cycle by cycle.
  // Cycle n=1 is the cycle that begins at the edge accepting start.
  // Returns one cycle after done, abort or reset is applied.
  task automatic run_main(input int rs1, input int rs2, input int ab_at, input int rst_at,
                          output int done_n, output int busy_n, output int vec_err,
                          output logic pass_at_done, output logic [4:0] fc_at1,
                          output logic [31:0] sig_at1);
    bit stop;
    int ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_n = 0; busy_n = 0; vec_err = 0; pass_at_done = 1'b0;
    fc_at1 = fail_count; sig_at1 = signature;
    for (int n = 1; n <= 100; n++) begin
      start = (n == rs1 || n == rs2);
      abort = (n == ab_at);
      rst   = (n == rst_at);
      if (busy === 1'b1) busy_n++;
      ev = (n - 1) / 2;
      if (ev > 15) ev = 15;
      if (vec !== 4'(ev)) vec_err++;
      stop = (done === 1'b1) || (n == ab_at) || (n == rst_at);
      if (done === 1'b1) begin
        done_n = n;
        pass_at_done = pass;
      end
      tick();
      if (stop) break;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  int          d_n, b_n, v_err, dones;
  logic        p_done;
  logic [4:0]  fc1;
  logic [31:0] sg1;

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_eq("rst_vec", 64'(vec), 64'h0);
    chk_eq("rst_busy", 64'(busy), 64'h0);
    chk_eq("rst_done", 64'(done), 64'h0);
    chk_eq("rst_pass", 64'(pass), 64'h0);
    chk_eq("rst_fail", 64'(fail_count), 64'h0);
    chk_eq("rst_sig", 64'(signature), 64'hFFFFFFFF);

    // 1: identical circuits
    mode = 2'd0;
    run_main(0, 0, 0, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s1_done_cycle", 64'(d_n), 64'd33);
    chk_eq("s1_busy_cycles", 64'(b_n), 64'd33);
    chk_eq("s1_vec_seq", 64'(v_err), 64'd0);
    chk_eq("s1_pass_at_done", 64'(p_done), 64'h1);
    chk_eq("s1_pass_after", 64'(pass), 64'h1);
    chk_eq("s1_busy_after", 64'(busy), 64'h0);
    chk_eq("s1_done_after", 64'(done), 64'h0);
    chk_eq("s1_fail", 64'(fail_count), 64'd0);
    chk_eq("s1_ffv", 64'(first_fail_vec), 64'd0);
    chk_eq("s1_vec_final", 64'(vec), 64'd15);
    chk_eq("s1_sig", 64'(signature), 64'(exp_sig(16)));

    // 2: single mismatch at vector 5
    mode = 2'd1;
    run_main(0, 0, 0, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s2_done_cycle", 64'(d_n), 64'd33);
    chk_eq("s2_pass_at_done", 64'(p_done), 64'h0);
    chk_eq("s2_pass_after", 64'(pass), 64'h0);
    chk_eq("s2_fail", 64'(fail_count), 64'd1);
    chk_eq("s2_ffv", 64'(first_fail_vec), 64'd5);
    chk_eq("s2_sig", 64'(signature), 64'(exp_sig(16)));

    // 3: every vector mismatches
    mode = 2'd2;
    run_main(0, 0, 0, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s3_done_cycle", 64'(d_n), 64'd33);
    chk_eq("s3_fail", 64'(fail_count), 64'd16);
    chk_eq("s3_ffv", 64'(first_fail_vec), 64'd0);
    chk_eq("s3_pass", 64'(pass), 64'h0);

    // 3b: SETTLE=3 instance, B inverted
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    d_n = 0;
    p_done = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      if (done3 === 1'b1) begin
        d_n = n;
        p_done = pass3;
        tick();
        break;
      end
      tick();
    end
    chk_eq("s3b_done_cycle", 64'(d_n), 64'd65);
    chk_eq("s3b_pass_at_done", 64'(p_done), 64'h0);
    chk_eq("s3b_fail", 64'(fail_count3), 64'd16);
    chk_eq("s3b_ffv", 64'(first_fail_vec3), 64'd0);
    chk_eq("s3b_busy_after", 64'(busy3), 64'h0);

    // 4: start re-pulsed mid-sweep and in the DONE cycle
    mode = 2'd0;
    run_main(4, 33, 0, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s4_start_clears_fail", 64'(fc1), 64'd0);
    chk_eq("s4_start_loads_seed", 64'(sg1), 64'hFFFFFFFF);
    chk_eq("s4_done_cycle", 64'(d_n), 64'd33);
    chk_eq("s4_vec_seq", 64'(v_err), 64'd0);
    chk_eq("s4_busy_cycles", 64'(b_n), 64'd33);
    chk_eq("s4_idle_after_done", 64'(busy), 64'h0);
    tick();
    chk_eq("s4_no_restart", 64'(busy), 64'h0);
    chk_eq("s4_vec_held", 64'(vec), 64'd15);

    // 5: abort during SAMPLE of vector 7 (mismatches at 2 and 7)
    mode = 2'd3;
    run_main(0, 0, 16, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s5_vec_seq", 64'(v_err), 64'd0);
    chk_eq("s5_no_done_before", 64'(d_n), 64'd0);
    chk_eq("s5_busy_after_abort", 64'(busy), 64'h0);
    chk_eq("s5_fail", 64'(fail_count), 64'd1);
    chk_eq("s5_ffv", 64'(first_fail_vec), 64'd2);
    chk_eq("s5_sig", 64'(signature), 64'(exp_sig(7)));
    chk_eq("s5_vec_held", 64'(vec), 64'd7);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk_eq("s5_no_done", 64'(dones), 64'd0);
    chk_eq("s5_pass", 64'(pass), 64'h0);
    mode = 2'd0;
    run_main(0, 0, 0, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s5_restart_clears", 64'(fc1), 64'd0);
    chk_eq("s5_restart_done", 64'(d_n), 64'd33);
    chk_eq("s5_restart_fail", 64'(fail_count), 64'd0);
    chk_eq("s5_restart_pass", 64'(pass), 64'h1);
    chk_eq("s5_restart_sig", 64'(signature), 64'(exp_sig(16)));

    // 6: reset at vector 9 while failures are accumulating
    mode = 2'd2;
    run_main(0, 0, 0, 19, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s6_vec_seq", 64'(v_err), 64'd0);
    chk_eq("s6_vec", 64'(vec), 64'd0);
    chk_eq("s6_busy", 64'(busy), 64'h0);
    chk_eq("s6_done", 64'(done), 64'h0);
    chk_eq("s6_pass", 64'(pass), 64'h0);
    chk_eq("s6_fail", 64'(fail_count), 64'd0);
    chk_eq("s6_ffv", 64'(first_fail_vec), 64'd0);
    chk_eq("s6_sig", 64'(signature), 64'hFFFFFFFF);
    mode = 2'd0;
    run_main(0, 0, 0, 0, d_n, b_n, v_err, p_done, fc1, sg1);
    chk_eq("s6_sweep_done", 64'(d_n), 64'd33);
    chk_eq("s6_sweep_busy", 64'(b_n), 64'd33);
    chk_eq("s6_sweep_pass", 64'(pass), 64'h1);
    chk_eq("s6_sweep_sig", 64'(signature), 64'(exp_sig(16)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
